mult_div_unit: RTL

//   Iterative multiply/divide unit for the multicycle MIPS EX stage. It sits beside
//   Alu and takes the same operand buses (input1 = rs, input2 = rt).
//   It implements MULT/MULTU (shift-add) and DIV/DIVU (restoring), plus MTHI/MTLO.

---
 rtl/mult_div_unit_if.sv | 24 ++
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the EX-stage control and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [2:0]       mdCtr;
  logic             start;
  logic             busy;
  logic             done;
  logic             divZero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output input1, input2, mdCtr, start,
    input  busy, done, divZero, hi, lo
  );

  modport slave (
    input  input1, input2, mdCtr, start,
    output busy, done, divZero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Signed operands are converted to magnitudes on entry and the signs are
// reapplied in a single FIX cycle after WIDTH iterations.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned W1    = WIDTH + 1;
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0]   work_q, work_d;  // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0]   opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divz_q, divz_d;

  logic               op_signed;
  logic               in_s1, in_s2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [W1-1:0]      mul_sum;
  logic [W1-1:0]      div_rem;
  logic [W1-1:0]      div_diff;
  logic [W2-1:0]      prod;
  logic [W2-1:0]      prod_neg;

  // Operand magnitudes and one-iteration datapath results.
  assign op_signed = ~bus.mdCtr[0];
  assign in_s1     = op_signed & bus.input1[WIDTH-1];
  assign in_s2     = op_signed & bus.input2[WIDTH-1];
  assign abs1      = in_s1 ? WIDTH'(-bus.input1) : bus.input1;
  assign abs2      = in_s2 ? WIDTH'(-bus.input2) : bus.input2;
  assign mul_sum   = W1'({1'b0, acc_q}) + (work_q[0] ? W1'({1'b0, opnd_q}) : W1'(0));
  assign div_rem   = {acc_q, work_q[WIDTH-1]};
  assign div_diff  = div_rem - W1'({1'b0, opnd_q});
  assign prod      = {acc_q, work_q};
  assign prod_neg  = W2'(0) - prod;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, iteration and result-writeback logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    divz_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mdCtr[2] == 1'b0) begin
            if (bus.mdCtr[1] && (bus.input2 == '0)) begin
              done_d = 1'b1;
              divz_d = 1'b1;
            end else begin
              state_d  = RUN;
              is_div_d = bus.mdCtr[1];
              s1_d     = in_s1;
              s2_d     = in_s2;
              acc_d    = '0;
              cnt_d    = '0;
              work_d   = bus.mdCtr[1] ? abs1 : abs2;
              opnd_d   = bus.mdCtr[1] ? abs2 : abs1;
            end
          end else if (bus.mdCtr == OP_MTHI) begin
            hi_d = bus.input1;
          end else if (bus.mdCtr == OP_MTLO) begin
            lo_d = bus.input1;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_d  = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
          work_d = {work_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d  = mul_sum[WIDTH:1];
          work_d = {mul_sum[0], work_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = (s1_q ^ s2_q) ? WIDTH'(-work_q) : work_q;
          hi_d = s1_q ? WIDTH'(-acc_q) : acc_q;
        end else begin
          {hi_d, lo_d} = (s1_q ^ s2_q) ? prod_neg : prod;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      divz_q   <= divz_d;
    end
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.divZero = divz_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule
